// File: rtl/axi_master_arbiter.sv
// Round-robin arbiter sharing the AXI burst master's write and read command ports between CLIENTS requesters.
// Define ARB_TIMEOUT_EN to enable the write-channel watchdog that pulses m_master_rst on a stalled burst.

// Channel FSM states:
//   state   | meaning
//   S_IDLE  | waiting for any request while the master is ready
//   S_ARB   | round-robin pick, latch address/length, drive grant
//   S_START | one-cycle start strobe to the master
//   S_BUSY  | transfer in flight, waiting for master done (or watchdog)
//   S_DONE  | one-cycle done pulse to the owner, release grant
module axi_arb_channel #(
  parameter int CLIENTS     = 2,
  parameter int TIMEOUT_CYC = 1048576,
  parameter bit WDOG        = 1'b0
) (
  input  logic                   ACLK,
  input  logic                   ARESETN,
  input  logic [CLIENTS-1:0]     req,
  input  logic [32*CLIENTS-1:0]  adrs,
  input  logic [32*CLIENTS-1:0]  len,
  output logic [CLIENTS-1:0]     gnt,
  output logic [CLIENTS-1:0]     done,
  output logic [CLIENTS-1:0]     err,
  output logic                   m_start,
  output logic [31:0]            m_adrs,
  output logic [31:0]            m_len,
  input  logic                   m_ready,
  input  logic                   m_done,
  output logic                   m_rst
);
  localparam int PW = (CLIENTS > 2) ? 2 : 1;

  typedef enum logic [2:0] {S_IDLE, S_ARB, S_START, S_BUSY, S_DONE} state_t;
  state_t state;

  logic [PW-1:0]      ptr;
  logic [PW-1:0]      owner;
  logic [PW-1:0]      idx;
  logic [PW-1:0]      pick;
  logic               pick_vld;
  logic [CLIENTS-1:0] pick_oh;
  logic [31:0]        pick_adrs;
  logic [31:0]        pick_len;
  logic [31:0]        pick_len_al;
  logic [31:0]        wd_cnt;

  // Scan ptr+1, ptr+2, ... so the last winner has lowest priority.
  always_comb begin
    idx       = '0;
    pick      = '0;
    pick_vld  = 1'b0;
    for (int i = 1; i <= CLIENTS; i++) begin
      idx = PW'((int'(ptr) + i) % CLIENTS);
      if (!pick_vld && req[idx]) begin
        pick_vld = 1'b1;
        pick     = idx;
      end
    end
    pick_oh       = '0;
    pick_oh[pick] = 1'b1;
    pick_adrs     = '0;
    pick_len      = '0;
    for (int c = 0; c < CLIENTS; c++) begin
      if (pick == PW'(c)) begin
        pick_adrs = adrs[32*c +: 32];
        pick_len  = len[32*c +: 32];
      end
    end
    pick_len_al = pick_len & 32'hFFFF_FFF8;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state   <= S_IDLE;
      ptr     <= PW'(CLIENTS - 1);
      owner   <= '0;
      gnt     <= '0;
      done    <= '0;
      err     <= '0;
      m_start <= 1'b0;
      m_adrs  <= '0;
      m_len   <= '0;
      m_rst   <= 1'b0;
      wd_cnt  <= '0;
    end else begin
      done  <= '0;
      err   <= '0;
      m_rst <= 1'b0;
      case (state)
        S_IDLE: begin
          if ((|req) && m_ready) state <= S_ARB;
        end
        S_ARB: begin
          if (!pick_vld) begin
            state <= S_IDLE;
          end else begin
            owner  <= pick;
            gnt    <= pick_oh;
            m_adrs <= pick_adrs;
            m_len  <= pick_len_al;
            // Sub-beat lengths never reach the master; complete immediately.
            if (pick_len_al == 32'd0) begin
              done  <= pick_oh;
              state <= S_DONE;
            end else begin
              m_start <= 1'b1;
              state   <= S_START;
            end
          end
        end
        S_START: begin
          m_start <= 1'b0;
          wd_cnt  <= '0;
          state   <= S_BUSY;
        end
        S_BUSY: begin
          if (WDOG && m_rst) begin
            done  <= gnt;
            err   <= gnt;
            state <= S_DONE;
          end else if (m_done) begin
            done  <= gnt;
            state <= S_DONE;
          end else if (WDOG) begin
            wd_cnt <= wd_cnt + 32'd1;
            if (wd_cnt == 32'(TIMEOUT_CYC - 1)) m_rst <= 1'b1;
          end
        end
        S_DONE: begin
          gnt   <= '0;
          ptr   <= owner;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

module axi_master_arbiter #(
  parameter int CLIENTS     = 2,
  parameter int TIMEOUT_CYC = 1048576
) (
  input  logic                   ACLK,
  input  logic                   ARESETN,
  input  logic [CLIENTS-1:0]     wr_req,
  input  logic [32*CLIENTS-1:0]  wr_adrs,
  input  logic [32*CLIENTS-1:0]  wr_len,
  output logic [CLIENTS-1:0]     wr_gnt,
  output logic [CLIENTS-1:0]     wr_done,
  output logic [CLIENTS-1:0]     wr_err,
  input  logic [CLIENTS-1:0]     rd_req,
  input  logic [32*CLIENTS-1:0]  rd_adrs,
  input  logic [32*CLIENTS-1:0]  rd_len,
  output logic [CLIENTS-1:0]     rd_gnt,
  output logic [CLIENTS-1:0]     rd_done,
  output logic                   m_wr_start,
  output logic [31:0]            m_wr_adrs,
  output logic [31:0]            m_wr_len,
  input  logic                   m_wr_ready,
  input  logic                   m_wr_done,
  output logic                   m_rd_start,
  output logic [31:0]            m_rd_adrs,
  output logic [31:0]            m_rd_len,
  input  logic                   m_rd_ready,
  input  logic                   m_rd_done,
  output logic                   m_master_rst
);
`ifdef ARB_TIMEOUT_EN
  localparam bit WR_WDOG = 1'b1;
`else
  localparam bit WR_WDOG = 1'b0;
`endif

  // MASTER_RST only aborts the write engine, so the read channel never has a watchdog.
  logic [CLIENTS-1:0] rd_err_unused;
  logic               rd_mrst_unused;

  axi_arb_channel #(
    .CLIENTS(CLIENTS), .TIMEOUT_CYC(TIMEOUT_CYC), .WDOG(WR_WDOG)
  ) u_wr (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .req(wr_req), .adrs(wr_adrs), .len(wr_len),
    .gnt(wr_gnt), .done(wr_done), .err(wr_err),
    .m_start(m_wr_start), .m_adrs(m_wr_adrs), .m_len(m_wr_len),
    .m_ready(m_wr_ready), .m_done(m_wr_done), .m_rst(m_master_rst)
  );

  axi_arb_channel #(
    .CLIENTS(CLIENTS), .TIMEOUT_CYC(TIMEOUT_CYC), .WDOG(1'b0)
  ) u_rd (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .req(rd_req), .adrs(rd_adrs), .len(rd_len),
    .gnt(rd_gnt), .done(rd_done), .err(rd_err_unused),
    .m_start(m_rd_start), .m_adrs(m_rd_adrs), .m_len(m_rd_len),
    .m_ready(m_rd_ready), .m_done(m_rd_done), .m_rst(rd_mrst_unused)
  );
endmodule

// File: tb/tb_axi_master_arbiter.sv
// Bench for axi_master_arbiter: directed and randomized transfers checked against a round-robin transaction model.
// Watchdog steps run only when ARB_TIMEOUT_EN is defined.
module tb_axi_master_arbiter;
  localparam int N  = 2;
  localparam int TO = 100;

  logic            ACLK = 1'b0;
  logic            ARESETN;
  logic [N-1:0]    wr_req, rd_req;
  logic [32*N-1:0] wr_adrs, wr_len, rd_adrs, rd_len;
  logic [N-1:0]    wr_gnt, wr_done, wr_err, rd_gnt, rd_done;
  logic            m_wr_start, m_wr_ready, m_wr_done;
  logic            m_rd_start, m_rd_ready, m_rd_done;
  logic [31:0]     m_wr_adrs, m_wr_len, m_rd_adrs, m_rd_len;
  logic            m_master_rst;

  axi_master_arbiter #(.CLIENTS(N), .TIMEOUT_CYC(TO)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .wr_req(wr_req), .wr_adrs(wr_adrs), .wr_len(wr_len),
    .wr_gnt(wr_gnt), .wr_done(wr_done), .wr_err(wr_err),
    .rd_req(rd_req), .rd_adrs(rd_adrs), .rd_len(rd_len),
    .rd_gnt(rd_gnt), .rd_done(rd_done),
    .m_wr_start(m_wr_start), .m_wr_adrs(m_wr_adrs), .m_wr_len(m_wr_len),
    .m_wr_ready(m_wr_ready), .m_wr_done(m_wr_done),
    .m_rd_start(m_rd_start), .m_rd_adrs(m_rd_adrs), .m_rd_len(m_rd_len),
    .m_rd_ready(m_rd_ready), .m_rd_done(m_rd_done),
    .m_master_rst(m_master_rst)
  );

  always #5 ACLK = ~ACLK;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;
  int last_w[2];   // model: last winner per channel (0 = write, 1 = read)

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  function automatic int rr_pick(input int ch, input logic [N-1:0] mask);
    for (int k = 1; k <= N; k++) begin
      if (mask[(last_w[ch] + k) % N]) return (last_w[ch] + k) % N;
    end
    return -1;
  endfunction

  // One transfer, entered with the channel in IDLE and the request already driven.
  task automatic txn(input bit rd, input int w, input logic [31:0] a, input logic [31:0] l, input int busy);
    logic [31:0] oh;
    oh = 32'd1 << w;
    tick();
    chk("arb_gnt",   rd ? rd_gnt : wr_gnt, 32'd0);
    chk("arb_start", rd ? m_rd_start : m_wr_start, 32'd0);
    tick();
    chk("grant", rd ? rd_gnt : wr_gnt, oh);
    if (l < 32'd8) begin
      chk("short_start", rd ? m_rd_start : m_wr_start, 32'd0);
      chk("short_done",  rd ? rd_done : wr_done, oh);
      chk("short_err",   wr_err, 32'd0);
      tick();
      chk("short_clear", rd ? rd_done : wr_done, 32'd0);
      chk("short_gnt",   rd ? rd_gnt : wr_gnt, 32'd0);
    end else begin
      chk("start", rd ? m_rd_start : m_wr_start, 32'd1);
      chk("adrs",  rd ? m_rd_adrs : m_wr_adrs, a);
      chk("len",   rd ? m_rd_len : m_wr_len, l - (l % 8));
      for (int k = 0; k < busy; k++) begin
        tick();
        chk("busy_start", rd ? m_rd_start : m_wr_start, 32'd0);
        chk("busy_gnt",   rd ? rd_gnt : wr_gnt, oh);
        chk("busy_done",  rd ? rd_done : wr_done, 32'd0);
        chk("busy_mrst",  m_master_rst, 32'd0);
      end
      if (rd) m_rd_done = 1'b1; else m_wr_done = 1'b1;
      tick();
      m_rd_done = 1'b0;
      m_wr_done = 1'b0;
      chk("done_pulse", rd ? rd_done : wr_done, oh);
      chk("done_gnt",   rd ? rd_gnt : wr_gnt, oh);
      chk("done_err",   wr_err, 32'd0);
      tick();
      chk("done_clear", rd ? rd_done : wr_done, 32'd0);
      chk("gnt_clear",  rd ? rd_gnt : wr_gnt, 32'd0);
    end
    last_w[rd] = w;
  endtask

  initial begin
    int w, r, n;
    bit rd;
    logic [N-1:0] mask;
    logic [31:0]  l;

    ARESETN = 1'b0;
    wr_req = '0; rd_req = '0;
    wr_adrs = '0; wr_len = '0; rd_adrs = '0; rd_len = '0;
    m_wr_ready = 1'b1; m_rd_ready = 1'b1;
    m_wr_done = 1'b0; m_rd_done = 1'b0;
    last_w = '{N - 1, N - 1};

    tick(); tick();
    chk("rst_wr_gnt", wr_gnt, 32'd0);
    chk("rst_rd_gnt", rd_gnt, 32'd0);
    chk("rst_wr_done", wr_done, 32'd0);
    chk("rst_wr_start", m_wr_start, 32'd0);
    chk("rst_rd_start", m_rd_start, 32'd0);
    chk("rst_wr_len", m_wr_len, 32'd0);
    chk("rst_mrst", m_master_rst, 32'd0);
    ARESETN = 1'b1;
    tick();

    // Single write from client 0
    wr_adrs = {32'h0, 32'h1000_0000};
    wr_len  = {32'h0, 32'd4096};
    wr_req  = 2'b01;
    txn(0, rr_pick(0, wr_req), 32'h1000_0000, 32'd4096, 3);
    wr_req  = '0;

    // Contention: both held, grants must alternate
    wr_adrs = {32'h2000_0000, 32'h3000_0000};
    wr_len  = {32'h1003, 32'h1003};
    wr_req  = 2'b11;
    for (int k = 0; k < 4; k++) begin
      w = rr_pick(0, wr_req);
      txn(0, w, wr_adrs[32*w +: 32], 32'h1003, 2);
    end
    wr_req = '0;

    // Length below one beat completes without starting the master
    wr_len = {32'h1003, 32'd4};
    wr_req = 2'b01;
    txn(0, rr_pick(0, wr_req), 32'h3000_0000, 32'd4, 1);
    wr_req = '0;

    // Request dropped while in ARB
    wr_req = 2'b01;
    tick();
    wr_req = '0;
    tick();
    chk("drop_gnt", wr_gnt, 32'd0);
    chk("drop_start", m_wr_start, 32'd0);
    tick();
    chk("drop_gnt2", wr_gnt, 32'd0);
    chk("drop_done", wr_done, 32'd0);

    // Master not ready holds the channel idle
    m_wr_ready = 1'b0;
    wr_req = 2'b10;
    repeat (4) tick();
    chk("nrdy_gnt", wr_gnt, 32'd0);
    chk("nrdy_start", m_wr_start, 32'd0);
    m_wr_ready = 1'b1;
    txn(0, rr_pick(0, wr_req), 32'h2000_0000, 32'h1003, 1);
    wr_req = '0;

    // Write and read start in the same cycle
    wr_len  = {32'h0, 32'd64};
    rd_adrs = {32'h4000_0000, 32'h5000_0000};
    rd_len  = {32'd256, 32'd8};
    wr_req  = 2'b01;
    rd_req  = 2'b10;
    w = rr_pick(0, wr_req);
    r = rr_pick(1, rd_req);
    tick(); tick();
    chk("cc_wr_start", m_wr_start, 32'd1);
    chk("cc_rd_start", m_rd_start, 32'd1);
    chk("cc_wr_gnt", wr_gnt, 32'd1 << w);
    chk("cc_rd_gnt", rd_gnt, 32'd1 << r);
    chk("cc_rd_adrs", m_rd_adrs, 32'h4000_0000);
    chk("cc_rd_len", m_rd_len, 32'd256);
    wr_req = '0; rd_req = '0;
    tick();
    m_rd_done = 1'b1;
    tick();
    m_rd_done = 1'b0;
    chk("cc_rd_done", rd_done, 32'd1 << r);
    chk("cc_wr_nodone", wr_done, 32'd0);
    chk("cc_wr_gnt_held", wr_gnt, 32'd1 << w);
    tick();
    chk("cc_rd_clear", rd_gnt, 32'd0);
    m_wr_done = 1'b1;
    tick();
    m_wr_done = 1'b0;
    chk("cc_wr_done", wr_done, 32'd1 << w);
    chk("cc_rd_nodone", rd_done, 32'd0);
    tick();
    chk("cc_wr_clear", wr_gnt, 32'd0);
    last_w[0] = w;
    last_w[1] = r;

    // Randomized transfers on either channel
    for (int it = 0; it < 24; it++) begin
      rd   = 1'($urandom_range(0, 1));
      mask = N'($urandom_range(1, 3));
      l    = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 7)) : (($urandom & 32'h000F_FFFF) | 32'h8);
      if (rd) begin
        rd_adrs = {$urandom, $urandom};
        rd_len  = {l, l};
        rd_req  = mask;
        w = rr_pick(1, mask);
        txn(1, w, rd_adrs[32*w +: 32], l, $urandom_range(1, 5));
        rd_req = '0;
      end else begin
        wr_adrs = {$urandom, $urandom};
        wr_len  = {l, l};
        wr_req  = mask;
        w = rr_pick(0, mask);
        txn(0, w, wr_adrs[32*w +: 32], l, $urandom_range(1, 5));
        wr_req = '0;
      end
      repeat ($urandom_range(0, 2)) tick();
    end

    // Reset in the middle of a busy write
    wr_len = {32'd512, 32'd512};
    wr_req = 2'b10;
    tick(); tick();
    chk("mid_start", m_wr_start, 32'd1);
    tick();
    ARESETN = 1'b0;
    #1;
    chk("mid_rst_gnt", wr_gnt, 32'd0);
    chk("mid_rst_done", wr_done, 32'd0);
    chk("mid_rst_start", m_wr_start, 32'd0);
    chk("mid_rst_adrs", m_wr_adrs, 32'd0);
    chk("mid_rst_len", m_wr_len, 32'd0);
    chk("mid_rst_rd_gnt", rd_gnt, 32'd0);
    wr_req = '0;
    tick();
    ARESETN = 1'b1;
    last_w = '{N - 1, N - 1};
    tick();
    chk("post_rst_done", wr_done, 32'd0);
    wr_req = 2'b11;
    w = rr_pick(0, wr_req);
    txn(0, w, wr_adrs[32*w +: 32], 32'd512, 2);
    wr_req = '0;

`ifdef ARB_TIMEOUT_EN
    // Stalled write: watchdog aborts after TO busy cycles
    wr_req = 2'b01;
    w = rr_pick(0, wr_req);
    tick(); tick();
    chk("wd_start", m_wr_start, 32'd1);
    n = 0;
    while (m_master_rst !== 1'b1 && n < 4 * TO) begin
      tick();
      n++;
    end
    chk("wd_delay", n, TO + 1);
    chk("wd_gnt", wr_gnt, 32'd1 << w);
    tick();
    chk("wd_rst_pulse", m_master_rst, 32'd0);
    chk("wd_done", wr_done, 32'd1 << w);
    chk("wd_err", wr_err, 32'd1 << w);
    wr_req = '0;
    tick();
    chk("wd_done_clear", wr_done, 32'd0);
    chk("wd_err_clear", wr_err, 32'd0);
    last_w[0] = w;
    wr_req = 2'b10;
    w = rr_pick(0, wr_req);
    txn(0, w, wr_adrs[32*w +: 32], 32'd512, 2);
    wr_req = '0;
`endif

    tick();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/axi_master_arbiter.md
Name: axi_master_arbiter

Overview:
- Shares the single local-bus command port of the 64-bit AXI burst master between CLIENTS requesters (e.g. SD BMP loader, video scan-out, CPU copy).
- Write and read channels are arbitrated independently, each with its own round-robin FSM.
- A granted client owns that channel's START/ADRS/LEN and its FIFO side (selected by its gnt bit) until the master pulses DONE.

Parameters:
- CLIENTS, 2: number of requesters; supported range 2..4.
- TIMEOUT_CYC, 1048576: write watchdog limit in ACLK cycles. Used only with ARB_TIMEOUT_EN.

Ports:
- ACLK  in  1  clock
- ARESETN  in  1  asynchronous active-low reset
- wr_req  in  CLIENTS  per-client write request, level
- wr_adrs  in  32*CLIENTS  byte address; client i occupies [32i+31:32i]
- wr_len  in  32*CLIENTS  byte length, multiple of 8
- wr_gnt  out  CLIENTS  one-hot, held for the whole transfer
- wr_done  out  CLIENTS  1-cycle completion pulse to the owner
- wr_err  out  CLIENTS  1-cycle pulse alongside wr_done on abort
- rd_req, rd_adrs, rd_len, rd_gnt, rd_done  same widths/meanings, read channel
- m_wr_start  out  1  to master WR_START
- m_wr_adrs  out  32  to master WR_ADRS
- m_wr_len  out  32  to master WR_LEN
- m_wr_ready  in  1  master WR_READY (write engine idle)
- m_wr_done  in  1  master WR_DONE pulse
- m_rd_start, m_rd_adrs, m_rd_len, m_rd_ready, m_rd_done  read equivalents
- m_master_rst  out  1  to master MASTER_RST

Behaviour:
- Reset: all outputs 0, both FSMs IDLE, round-robin pointers = CLIENTS-1, so client 0 wins first.
- Per-channel FSM states: IDLE, ARB, START, BUSY, DONE.
- IDLE: go to ARB when (|req) and m_ready.
- ARB: pick the first requester scanning ptr+1, ptr+2, ... (mod CLIENTS).
  - Latch its adrs, and its len with [2:0] forced to 0, into m_adrs/m_len. These are stable from START until DONE.
  - Set gnt[winner], then go to START.
  - If no req is still high in ARB (requests dropped), return to IDLE; nothing is granted.
  - If the latched len[31:3] == 0: do not start the master. Go directly to DONE (done pulse, no err).
- START: m_start = 1 for exactly one cycle, then BUSY.
- BUSY: wait for m_done, then go to DONE. An m_done seen in any other state is ignored.
- DONE: done[winner] = 1 for one cycle, gnt cleared, ptr <= winner, then IDLE.
- Latency:
  - req to m_start: 2 cycles (IDLE→ARB→START) when the master is ready.
  - m_done to done pulse: 1 cycle.
  - Back-to-back grants: 1 idle cycle minimum between DONE and the next ARB.
- Fairness: a client holding req continuously is served at most once per round while others request.
- Channels are fully independent. Write and read may be BUSY simultaneously, and may start in the same cycle.
- Client FIFO steering (WR_FIFO_RE/DATA, RD_FIFO_WE) is muxed outside this block, using gnt.
- gnt changes only in ARB and DONE, never mid-transfer.
- ARESETN low at any point: immediate return to reset values. An in-flight transfer is abandoned with no done pulse.
- m_master_rst is 0 unless ARB_TIMEOUT_EN is defined.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A 32-bit counter clears in START and increments each BUSY cycle on the write channel.
  - When it reaches TIMEOUT_CYC: m_master_rst = 1 for one cycle, then DONE with wr_done and wr_err pulsed together.
  - The read channel has no watchdog, because MASTER_RST aborts only the master's write engine.
- Undefined:
  - No counter; m_master_rst and wr_err are tied 0.
  - BUSY waits indefinitely for m_done.

Test Plan:
- Single write: client0 req, adrs 0x1000_0000, len 4096, master ready → m_wr_start 2 cycles later with adrs 0x1000_0000 and len 4096; m_wr_done → wr_done[0] 1 cycle later; wr_gnt[0] high throughout.
- Contention: wr_req = 2'b11 held → grants alternate 0,1,0,1; wr_len 0x1003 is forwarded as 0x1000.
- Concurrency: rd client1 and wr client0 request in the same cycle → m_rd_start and m_wr_start assert in the same cycle; each done routes to its own owner.
- Boundaries:
  - len = 4 → done pulse without m_wr_start.
  - req dropped before ARB → no grant.
  - m_wr_ready = 0 → stays IDLE.
- Reset mid-BUSY: ARESETN low → all gnt, done and m_* outputs 0 immediately; after release, client 0 wins first.
- ARB_TIMEOUT_EN with TIMEOUT_CYC = 100 and no m_wr_done → m_master_rst pulse 100 BUSY cycles after START, then wr_done and wr_err pulse; the next request proceeds normally.
